// File: rtl/pc_gen.sv
// Fetch-address generator with a valid/ready fetch handshake and prioritised redirects.
// It also keeps an epoch tag for squashing stale fetches and has a misaligned-target fault state.
module pc_gen #(
    parameter int unsigned         XLEN         = 32,
    parameter logic [XLEN-1:0]     RESET_VECTOR = '0,
    parameter int unsigned         IALIGN       = 4,
    parameter int unsigned         EPOCH_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               fetch_ready,
    input  logic               trap_valid,
    input  logic [XLEN-1:0]    trap_target,
    input  logic               br_valid,
    input  logic [XLEN-1:0]    br_target,
    input  logic               jmp_valid,
    input  logic [XLEN-1:0]    jmp_target,
    output logic               fetch_valid,
    output logic [XLEN-1:0]    fetch_pc,
    output logic [EPOCH_W-1:0] fetch_epoch,
    output logic               misalign_fault,
    output logic [XLEN-1:0]    misalign_addr
);

    localparam logic [XLEN-1:0]    ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0]    PC_STEP    = XLEN'(IALIGN);
    localparam logic [EPOCH_W-1:0] EPOCH_ONE  = EPOCH_W'(1);

    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

    state_t            state;
    logic              br_aligned;
    logic              jmp_aligned;
    logic [XLEN-1:0]   trap_pc;

    // Traps are never faulted: the low bits are simply dropped.
    assign trap_pc     = trap_target & ~ALIGN_MASK;
    assign br_aligned  = (br_target & ALIGN_MASK) == '0;
    assign jmp_aligned = (jmp_target & ALIGN_MASK) == '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= BOOT;
            fetch_valid    <= 1'b0;
            fetch_pc       <= RESET_VECTOR;
            fetch_epoch    <= '0;
            misalign_fault <= 1'b0;
            misalign_addr  <= '0;
        end else begin
            misalign_fault <= 1'b0;
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                    fetch_pc    <= RESET_VECTOR;
                end
                RUN: begin
                    if (trap_valid) begin
                        fetch_pc    <= trap_pc;
                        fetch_epoch <= fetch_epoch + EPOCH_ONE;
                    end else if (br_valid) begin
                        if (br_aligned) begin
                            fetch_pc    <= br_target;
                            fetch_epoch <= fetch_epoch + EPOCH_ONE;
                        end else begin
                            state          <= FAULT;
                            fetch_valid    <= 1'b0;
                            misalign_fault <= 1'b1;
                            misalign_addr  <= br_target;
                        end
                    end else if (jmp_valid) begin
                        if (jmp_aligned) begin
                            fetch_pc    <= jmp_target;
                            fetch_epoch <= fetch_epoch + EPOCH_ONE;
                        end else begin
                            state          <= FAULT;
                            fetch_valid    <= 1'b0;
                            misalign_fault <= 1'b1;
                            misalign_addr  <= jmp_target;
                        end
                    end else if (fetch_valid && fetch_ready && !stall) begin
                        fetch_pc <= fetch_pc + PC_STEP;
                    end
                end
                FAULT: begin
                    // Only a trap leaves FAULT; branch and jump requests are ignored here.
                    if (trap_valid) begin
                        state       <= RUN;
                        fetch_valid <= 1'b1;
                        fetch_pc    <= trap_pc;
                        fetch_epoch <= fetch_epoch + EPOCH_ONE;
                    end
                end
                default: begin
                    state       <= BOOT;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
